pwm_carrier_nch: RTL and testbench

PWM_CARRIER_NCH -- requirements
Module: pwm_carrier_nch

---
 rtl/pwm_carrier_nch.sv | 209 ++++++++++++++++++++
 tb/tb_pwm_carrier_nch.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_carrier_nch.sv
// Multi-channel complementary PWM: shared carrier with sync-gated compare shadowing.
// Optional dead-time insertion is enabled by defining PWM_CARRIER_DEADTIME_EN.

module pwm_carrier_nch_lane #(
  parameter int WIDTH    = 16,
  parameter int DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                sync,
  input  logic [WIDTH-1:0]    carrier,
  input  logic [WIDTH-1:0]    compare,
  input  logic                sig_pwm,
  input  logic [DT_WIDTH-1:0] dead_time,
  output logic                pwm_a,
  output logic                pwm_b
);

  logic [WIDTH-1:0] active_cmp;
  logic             raw;

  // Active compare moves only on a sync pulse, so duty changes land on period boundaries.
  always_ff @(posedge clk) begin
    if (rst)       active_cmp <= compare;
    else if (sync) active_cmp <= compare;
  end

  assign raw = (carrier < active_cmp) ^ sig_pwm;

`ifdef PWM_CARRIER_DEADTIME_EN
  logic                raw_q;
  logic [DT_WIDTH-1:0] dt_cnt;

  // Any raw edge (re)starts the blanking window; the new side drives once it expires.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_a  <= 1'b0;
      pwm_b  <= 1'b0;
      raw_q  <= 1'b0;
      dt_cnt <= '0;
    end else if (ce) begin
      if (raw != raw_q) begin
        raw_q <= raw;
        if (dead_time == '0) begin
          pwm_a  <= raw;
          pwm_b  <= ~raw;
          dt_cnt <= '0;
        end else begin
          pwm_a  <= 1'b0;
          pwm_b  <= 1'b0;
          dt_cnt <= dead_time;
        end
      end else if (dt_cnt != '0) begin
        dt_cnt <= dt_cnt - 1'b1;
        if (dt_cnt == DT_WIDTH'(1)) begin
          pwm_a <= raw_q;
          pwm_b <= ~raw_q;
        end
      end else begin
        pwm_a <= raw;
        pwm_b <= ~raw;
      end
    end
  end
`else
  logic unused_dt;
  assign unused_dt = ^dead_time;

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_a <= 1'b0;
      pwm_b <= 1'b0;
    end else if (ce) begin
      pwm_a <= raw;
      pwm_b <= ~raw;
    end
  end
`endif

endmodule

module pwm_carrier_nch #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int DT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic [WIDTH-1:0]          count_max,
  input  logic [WIDTH-1:0]          init_carr,
  input  logic                      load,
  input  logic [1:0]                count_mode,
  input  logic [1:0]                sync_mode,
  input  logic [3:0]                event_count,
  input  logic [CHANNELS*WIDTH-1:0] compare,
  input  logic [CHANNELS-1:0]       sig_pwm,
  input  logic [DT_WIDTH-1:0]       dead_time,
  output logic [WIDTH-1:0]          carrier,
  output logic                      sync,
  output logic [CHANNELS-1:0]       pwm_a,
  output logic [CHANNELS-1:0]       pwm_b
);

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_UP   = 2'b10;
  localparam logic [1:0] MODE_UPDN = 2'b11;

  logic [WIDTH-1:0] carrier_q, carrier_nxt, init_clip;
  logic             dir_up_q, dir_up_nxt;
  logic [3:0]       evt_cnt_q;
  logic             sync_q;
  logic             evt_min, evt_max, evt_sel;

  assign init_clip = (init_carr > count_max) ? count_max : init_carr;

  always_comb begin
    carrier_nxt = carrier_q;
    dir_up_nxt  = dir_up_q;
    if (load) begin
      carrier_nxt = init_clip;
      dir_up_nxt  = 1'b1;
    end else begin
      case (count_mode)
        MODE_UP:
          carrier_nxt = (carrier_q >= count_max) ? '0 : carrier_q + 1'b1;
        MODE_DOWN:
          if (carrier_q > count_max || carrier_q == '0) carrier_nxt = count_max;
          else                                          carrier_nxt = carrier_q - 1'b1;
        MODE_UPDN: begin
          // Reverse at each terminal without repeating it; count_max==0 pins at 0.
          if (carrier_q > count_max) begin
            carrier_nxt = '0;
            dir_up_nxt  = 1'b1;
          end else if (count_max == '0) begin
            carrier_nxt = '0;
          end else if (dir_up_q) begin
            if (carrier_q == count_max) begin
              carrier_nxt = carrier_q - 1'b1;
              dir_up_nxt  = 1'b0;
            end else begin
              carrier_nxt = carrier_q + 1'b1;
            end
          end else begin
            if (carrier_q == '0) begin
              carrier_nxt = carrier_q + 1'b1;
              dir_up_nxt  = 1'b1;
            end else begin
              carrier_nxt = carrier_q - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign evt_min = (count_mode != MODE_NONE) && (carrier_q == '0);
  assign evt_max = (count_mode != MODE_NONE) && (carrier_q == count_max);
  assign evt_sel = (sync_mode[0] & evt_min) | (sync_mode[1] & evt_max);

  // A coincident min+max (count_max==0) counts as a single event.
  always_ff @(posedge clk) begin
    if (rst) begin
      carrier_q <= init_clip;
      dir_up_q  <= 1'b1;
      evt_cnt_q <= '0;
      sync_q    <= 1'b0;
    end else begin
      sync_q <= 1'b0;
      if (ce) begin
        carrier_q <= carrier_nxt;
        dir_up_q  <= dir_up_nxt;
        if (evt_sel) begin
          if (evt_cnt_q >= event_count) begin
            evt_cnt_q <= '0;
            sync_q    <= 1'b1;
          end else begin
            evt_cnt_q <= evt_cnt_q + 1'b1;
          end
        end
      end
    end
  end

  assign carrier = carrier_q;
  assign sync    = sync_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    pwm_carrier_nch_lane #(
      .WIDTH    (WIDTH),
      .DT_WIDTH (DT_WIDTH)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .sync      (sync_q),
      .carrier   (carrier_q),
      .compare   (compare[i*WIDTH +: WIDTH]),
      .sig_pwm   (sig_pwm[i]),
      .dead_time (dead_time),
      .pwm_a     (pwm_a[i]),
      .pwm_b     (pwm_b[i])
    );
  end

endmodule

// File: tb/tb_pwm_carrier_nch.sv
// Scoreboard bench for pwm_carrier_nch: stimulus pushes expectations, a negedge monitor checks.
module tb_pwm_carrier_nch;

  logic        clk = 1'b0;
  logic        rst, ce, load;
  logic [15:0] count_max, init_carr;
  logic [1:0]  count_mode, sync_mode;
  logic [3:0]  event_count;
  logic [63:0] compare;
  logic [3:0]  sig_pwm;
  logic [7:0]  dead_time;
  logic [15:0] carrier;
  logic        sync;
  logic [3:0]  pwm_a, pwm_b;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] c;
    logic        cs;
    logic        s;
    logic        cp;
    logic [3:0]  a;
    logic [3:0]  b;
  } exp_t;

  exp_t  sbq[$];
  string nmq[$];

  pwm_carrier_nch dut (
    .clk(clk), .rst(rst), .ce(ce), .count_max(count_max), .init_carr(init_carr),
    .load(load), .count_mode(count_mode), .sync_mode(sync_mode),
    .event_count(event_count), .compare(compare), .sig_pwm(sig_pwm),
    .dead_time(dead_time), .carrier(carrier), .sync(sync), .pwm_a(pwm_a), .pwm_b(pwm_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t  e;
      string nm;
      e  = sbq.pop_front();
      nm = nmq.pop_front();
      checks++;
      if (carrier !== e.c) begin
        errors++;
        $display("FAIL %s carrier got %0h want %0h", nm, carrier, e.c);
      end
      if (e.cs) begin
        checks++;
        if (sync !== e.s) begin
          errors++;
          $display("FAIL %s sync got %0b want %0b (carrier %0h)", nm, sync, e.s, carrier);
        end
      end
      if (e.cp) begin
        checks++;
        if (pwm_a !== e.a || pwm_b !== e.b) begin
          errors++;
          $display("FAIL %s pwm got a=%b b=%b want a=%b b=%b (carrier %0h)",
                   nm, pwm_a, pwm_b, e.a, e.b, carrier);
        end
      end
    end
  end

  task automatic cyc(input string nm, input logic [15:0] c, input logic cs, input logic s,
                     input logic cp, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    @(posedge clk);
    #1;
    e.c = c; e.cs = cs; e.s = s; e.cp = cp; e.a = a; e.b = b;
    sbq.push_back(e);
    nmq.push_back(nm);
  endtask

  task automatic dn(input string nm, input logic [15:0] c, input logic s);
    cyc(nm, c, 1'b1, s, 1'b1, 4'h0, 4'hF);
  endtask

  task automatic setup(input logic [15:0] cm, input logic [15:0] ic, input logic [1:0] cmode,
                       input logic [1:0] smode, input logic [3:0] ec);
    count_max = cm; init_carr = ic; count_mode = cmode; sync_mode = smode; event_count = ec;
  endtask

  function automatic int tri_c(int m);
    int p;
    p = m % 510;
    return (p <= 255) ? p : 510 - p;
  endfunction

  function automatic logic ideal(int n, int cmp);
    if (n < 1) return 1'b0;
    return ((n - 1) % 20) < cmp;
  endfunction

  task automatic dt_run(input string nm, input int d, input int cycles);
    int cmp[4];
    cmp[0] = 8; cmp[1] = 1; cmp[2] = 0; cmp[3] = 0;
    for (int n = 1; n <= cycles; n++) begin
      logic [3:0] a, b;
      for (int ch = 0; ch < 4; ch++) begin
        logic st, v;
        st = 1'b1;
        v  = ideal(n, cmp[ch]);
        for (int k = 1; k <= d; k++) if (ideal(n - k, cmp[ch]) != v) st = 1'b0;
        a[ch] = st & v;
        b[ch] = st & ~v;
        if (a[ch] & b[ch]) begin a[ch] = 1'b0; b[ch] = 1'b0; end
      end
      cyc(nm, 16'(n % 20), 1'b0, 1'b0, 1'b1, a, b);
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; load = 1'b0; sig_pwm = 4'b1000; dead_time = 8'd0;
    compare = {16'd4, 16'd10, 16'd0, 16'd4};
    setup(16'd9, 16'd0, 2'b10, 2'b01, 4'd0);

    // Up mode period 10, mixed compares/polarity, sync on every min.
    cyc("up_rst", 16'd0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0);
    rst = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      int c;
      logic [3:0] a;
      c = (n - 1) % 10;
      a = {~(c < 4), 1'b1, 1'b0, (c < 4)};
      cyc("up", 16'(n % 10), 1'b1, ((n - 1) % 10) == 0, 1'b1, a, ~a);
    end

    // Shadow compare update on ch1 mid-period.
    rst = 1'b1; sig_pwm = 4'b0000;
    compare = {16'd0, 16'd0, 16'h001F, 16'h001F};
    setup(16'd99, 16'd0, 2'b10, 2'b01, 4'd0);
    cyc("shd_rst", 16'd0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0);
    rst = 1'b0;
    for (int n = 1; n <= 210; n++) begin
      int m, c;
      logic [3:0] a;
      if (n == 41) compare[31:16] = 16'h002F;
      m = n - 1;
      c = m % 100;
      a = {2'b00, (c < ((m >= 102) ? 47 : 31)), (c < 31)};
      cyc("shadow", 16'(n % 100), 1'b1, (m % 100) == 0, 1'b1, a, ~a);
    end

    // Up-down 255, every third min/max event.
    rst = 1'b1;
    compare = {16'd0, 16'd0, 16'd0, 16'd128};
    setup(16'd255, 16'd0, 2'b11, 2'b11, 4'd2);
    cyc("ud_rst", 16'd0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0);
    rst = 1'b0;
    for (int n = 1; n <= 1600; n++) begin
      int m;
      logic [3:0] a;
      m = n - 1;
      a = {3'b000, (tri_c(m) < 128)};
      cyc("updown", 16'(tri_c(n)), 1'b1, (m >= 510) && (((m - 510) % 765) == 0), 1'b1, a, ~a);
    end

    // Down mode, load clipping, out-of-range carrier, direction reset, count_max=0.
    rst = 1'b1;
    compare = '0;
    setup(16'h00FF, 16'd2, 2'b01, 2'b00, 4'd0);
    cyc("dn_rst", 16'd2, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0);
    rst = 1'b0;
    dn("dn", 16'd1, 1'b0);
    dn("dn", 16'd0, 1'b0);
    dn("dn_wrap", 16'h00FF, 1'b0);
    dn("dn", 16'h00FE, 1'b0);
    init_carr = 16'h05FF; load = 1'b1;
    dn("load_clip", 16'h00FF, 1'b0);
    load = 1'b0;
    dn("dn_after_load", 16'h00FE, 1'b0);
    dn("dn_after_load", 16'h00FD, 1'b0);
    count_mode = 2'b00;
    dn("none_hold", 16'h00FD, 1'b0);
    dn("none_hold", 16'h00FD, 1'b0);
    count_mode = 2'b01; count_max = 16'h0010;
    dn("dn_over", 16'h0010, 1'b0);
    dn("dn_over", 16'h000F, 1'b0);
    count_mode = 2'b10; count_max = 16'h0008;
    dn("up_over", 16'h0000, 1'b0);
    dn("up_over", 16'h0001, 1'b0);
    count_mode = 2'b11; count_max = 16'h0003;
    dn("ud_small", 16'd2, 1'b0);
    dn("ud_small", 16'd3, 1'b0);
    dn("ud_rev", 16'd2, 1'b0);
    dn("ud_rev", 16'd1, 1'b0);
    init_carr = 16'd2; load = 1'b1;
    dn("ud_load", 16'd2, 1'b0);
    load = 1'b0;
    dn("ud_dir_up", 16'd3, 1'b0);
    setup(16'd0, 16'd2, 2'b10, 2'b01, 4'd0);
    dn("cm0_wrap", 16'd0, 1'b0);
    for (int k = 0; k < 4; k++) dn("cm0_up_sync", 16'd0, 1'b1);
    count_mode = 2'b11;
    for (int k = 0; k < 2; k++) dn("cm0_ud_sync", 16'd0, 1'b1);
    count_mode = 2'b00;
    for (int k = 0; k < 2; k++) dn("cm0_none", 16'd0, 1'b0);

    // Clock-enable freeze and mid-period reset.
    rst = 1'b1;
    compare = {16'd0, 16'd0, 16'd0, 16'd4};
    setup(16'd9, 16'd1, 2'b10, 2'b01, 4'd0);
    cyc("ce_rst", 16'd1, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0);
    rst = 1'b0;
    cyc("ce_run", 16'd2, 1'b1, 1'b0, 1'b1, 4'h1, 4'hE);
    cyc("ce_run", 16'd3, 1'b1, 1'b0, 1'b1, 4'h1, 4'hE);
    cyc("ce_run", 16'd4, 1'b1, 1'b0, 1'b1, 4'h1, 4'hE);
    ce = 1'b0;
    compare[15:0] = 16'd9;
    for (int k = 0; k < 20; k++) cyc("ce_freeze", 16'd4, 1'b1, 1'b0, 1'b1, 4'h1, 4'hE);
    ce = 1'b1;
    cyc("ce_resume", 16'd5, 1'b1, 1'b0, 1'b1, 4'h0, 4'hF);
    cyc("ce_resume", 16'd6, 1'b1, 1'b0, 1'b1, 4'h0, 4'hF);
    rst = 1'b1; ce = 1'b0;
    cyc("rst_no_ce", 16'd1, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0);
    ce = 1'b1;
    cyc("rst_hold", 16'd1, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0);
    rst = 1'b0;
    cyc("after_rst", 16'd2, 1'b1, 1'b0, 1'b1, 4'h1, 4'hE);

`ifdef PWM_CARRIER_DEADTIME_EN
    // Dead time: ch0 long pulses, ch1 single-cycle pulse restarts blanking.
    rst = 1'b1; dead_time = 8'd3;
    compare = {16'd0, 16'd0, 16'd1, 16'd8};
    setup(16'd19, 16'd0, 2'b10, 2'b00, 4'd0);
    cyc("dt_rst", 16'd0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
    rst = 1'b0;
    dt_run("dt3", 3, 60);
    rst = 1'b1; dead_time = 8'd0;
    cyc("dt0_rst", 16'd0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
    rst = 1'b0;
    dt_run("dt0", 0, 25);
`endif

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
